// File: rtl/prime_gen.sv
// Ascending prime generator: trial division one divisor per clock, primes
// streamed out on a valid/ready handshake, one-cycle done pulse per run.
//
// state   | meaning
// IDLE    | waiting for start, count holds last run's total
// CHECK   | testing cand against div, one divisor per cycle
// EMIT    | cand is prime, offered on p_data until accepted
// ADVANCE | move to next candidate or finish at lim
// DONE    | one-cycle done pulse, then back to IDLE
module prime_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  output logic             p_valid,
  input  logic             p_ready,
  output logic [WIDTH-1:0] p_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    EMIT,
    ADVANCE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic [2*WIDTH-1:0] div_sq;
  logic [2*WIDTH-1:0] cand_ext;
  logic [WIDTH-1:0]   rem;

  // Square at double width so the "div*div > cand" test can never overflow.
  assign div_sq   = {{WIDTH{1'b0}}, div_q} * {{WIDTH{1'b0}}, div_q};
  assign cand_ext = {{WIDTH{1'b0}}, cand_q};
  assign rem      = cand_q % div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      div_q   <= '0;
      lim_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      div_q   <= div_d;
      lim_q   <= lim_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    div_d   = div_q;
    lim_d   = lim_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          lim_d   = limit;
          count_d = '0;
          if (limit < WIDTH'(2)) begin
            state_d = DONE;
          end else begin
            cand_d  = WIDTH'(2);
            div_d   = WIDTH'(2);
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (div_sq > cand_ext) begin
          state_d = EMIT;
        end else if (rem == '0) begin
          state_d = ADVANCE;
        end else begin
          div_d = div_q + WIDTH'(1);
        end
      end
      EMIT: begin
        if (p_ready) begin
          count_d = count_q + WIDTH'(1);
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        // Compare before incrementing so a full-scale limit never wraps cand.
        if (cand_q == lim_q) begin
          state_d = DONE;
        end else begin
          cand_d  = cand_q + WIDTH'(1);
          div_d   = WIDTH'(2);
          state_d = CHECK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign p_valid = (state_q == EMIT);
  assign p_data  = (state_q == EMIT) ? cand_q : '0;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign count   = count_q;

endmodule

// File: tb/tb_prime_gen.sv
// Self-checking bench for prime_gen: a trial-division reference fills a
// scoreboard queue at start, and every accepted prime is popped and compared.
module tb_prime_gen;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             p_valid;
  logic             p_ready;
  logic [WIDTH-1:0] p_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] count;

  prime_gen #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .limit   (limit),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .p_data  (p_data),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int hs_cnt = 0;
  int done_cnt = 0;
  int valid_cyc = 0;
  int last_hs = -1;
  int stall3 = 0;
  logic prev_stall = 1'b0;
  int   prev_data = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit ref_is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d < v; d++) begin
      if (v % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("bp_valid_held", int'(p_valid), 1);
        chk("bp_data_held", int'(p_data), prev_data);
      end
      prev_stall = p_valid && !p_ready;
      prev_data  = int'(p_data);
      if (p_valid && !p_ready && p_data == 8'd3) stall3++;
      if (p_valid) valid_cyc++;
      if (done) done_cnt++;
      if (p_valid && p_ready) begin
        hs_cnt++;
        last_hs = int'(p_data);
        if (exp_q.size() == 0) begin
          chk("extra_prime", int'(p_data), -1);
        end else begin
          chk("prime", int'(p_data), exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_expected(input int lim_v, output int n);
    n = 0;
    for (int v = 2; v <= lim_v; v++) begin
      if (ref_is_prime(v)) begin
        exp_q.push_back(v);
        n++;
      end
    end
  endtask

  task automatic run(input int lim_v, input int budget);
    int exp_n;
    int cyc;
    int first;
    int hs_base;
    int done_base;
    int valid_base;
    push_expected(lim_v, exp_n);
    hs_base    = hs_cnt;
    done_base  = done_cnt;
    valid_base = valid_cyc;
    @(posedge clk); #1;
    start = 1'b1;
    limit = 8'(lim_v);
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    first = -1;
    while (!done && cyc < budget) begin
      if (p_valid && first < 0) first = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", int'(done), 1);
    chk("count", int'(count), exp_n);
    chk("busy_at_done", int'(busy), 1);
    if (lim_v < 2) begin
      chk("deg_latency", cyc, 1);
      chk("deg_no_valid", valid_cyc - valid_base, 0);
    end else begin
      chk("first_latency", first, 2);
    end
    @(posedge clk); #1;
    chk("busy_idle", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
    chk("count_hold", int'(count), exp_n);
    chk("leftover", exp_q.size(), 0);
    chk("handshakes", hs_cnt - hs_base, exp_n);
    chk("done_pulses", done_cnt - done_base, 1);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int seen;
    int done_base;
    rst_n   = 1'b0;
    start   = 1'b0;
    limit   = '0;
    p_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(p_valid), 0);
    chk("rst_data", int'(p_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    rst_n = 1'b1;

    // Basic run
    run(10, 500);

    // Backpressure: stall 6 cycles once 3 is offered
    fork
      run(10, 500);
      begin
        seen = 0;
        for (int i = 0; i < 500 && seen == 0; i++) begin
          @(posedge clk); #1;
          if (p_valid && p_data == 8'd3) seen = 1;
        end
        chk("bp_saw_3", seen, 1);
        p_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        p_ready = 1'b1;
      end
    join
    chk("bp_stall_cycles", stall3, 6);

    // Degenerate bounds
    run(0, 50);
    run(1, 50);
    run(2, 50);

    // Full range
    run(255, 20000);
    chk("last_prime_255", last_hs, 251);

    // Ignored start mid-run
    fork
      run(10, 500);
      begin
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        limit = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        limit = 8'd10;
      end
    join

    // Reset mid-run while 5 is being offered
    push_expected(10, n);
    @(posedge clk); #1;
    start = 1'b1;
    limit = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 500 && seen == 0; i++) begin
      if (p_valid && p_data == 8'd5) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("rst_saw_5", seen, 1);
    done_base = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("async_valid", int'(p_valid), 0);
    chk("async_data", int'(p_data), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_count", int'(count), 0);
    chk("rst_pending", exp_q.size(), 2);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - done_base, 0);
    run(7, 500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prime_gen.md
Name: prime_gen

Overview:
- Sequential generator producing, in ascending order, every prime p with 2 <= p <= limit.
- Counterpart to the combinational 3-bit prime checker (checkP): the checker classifies a given n, this block searches for and emits the primes.
- Primality is decided by sequential trial division, one divisor per clock.
- Primes leave on a valid/ready stream; a one-cycle done pulse ends each run.

Parameters:
- WIDTH, 8, bit width of candidates, limit, p_data and count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- limit  input  WIDTH  inclusive upper bound; captured on accepted start.
- p_valid  output  1  p_data holds a prime.
- p_ready  input  1  consumer accepts p_data when p_valid && p_ready.
- p_data  output  WIDTH  current prime.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of run.
- count  output  WIDTH  primes accepted in current/last run.

Behaviour:
- Reset (rst_n low, async): state=IDLE; p_valid=0, p_data=0, busy=0, done=0, count=0; internal cand=0, div=0, lim=0.
- Reset mid-run aborts immediately. No pending prime survives. No done pulse is produced.
- FSM states: IDLE, CHECK, EMIT, ADVANCE, DONE.
- IDLE:
  - On start=1: lim<=limit, count<=0.
  - If limit<2: next state DONE.
  - Else: cand<=2, div<=2, next state CHECK.
  - start is ignored in all other states.
- CHECK (one divisor per cycle):
  - Compute div*div at 2*WIDTH bits, so there is no overflow.
  - If div*div > cand: prime, go EMIT.
  - Else if cand % div == 0: composite, go ADVANCE.
  - Else: div<=div+1, stay in CHECK.
- EMIT:
  - p_valid=1 and p_data=cand, both combinational from state/cand.
  - Values are held stable until handshake; p_ready may be low indefinitely.
  - On handshake: count<=count+1, go ADVANCE.
- ADVANCE:
  - If cand==lim: go DONE.
  - Else: cand<=cand+1, div<=2, go CHECK.
  - Compare-before-increment means limit=2^WIDTH-1 never wraps cand.
- DONE: done=1 for exactly this cycle, then IDLE. count holds its value until the next accepted start.
- p_valid is 0 in every state except EMIT. p_data is only meaningful when p_valid=1.
- Latency:
  - First prime (2): start edge -> CHECK -> EMIT, so p_valid rises on the second cycle after start is sampled.
  - Each CHECK iteration costs 1 cycle; each ADVANCE costs 1 cycle.
- Run length is bounded (cand and div both monotonic), so done is guaranteed given eventual p_ready.
- limit changes after start have no effect (captured in lim).

Test Plan:
- Basic run:
  - Stimulus: reset, then start=1 for 1 cycle with limit=10 and p_ready tied 1.
  - Required: p_data stream 2,3,5,7; exactly 4 handshakes; done pulses once after 7; count=4; busy falls with done.
- Backpressure:
  - Stimulus: limit=10, p_ready=0 for 6 cycles when p_data=3 appears.
  - Required: p_valid stays 1 and p_data stays 3 throughout; no duplicate or skipped primes; final count=4.
- Degenerate bounds:
  - limit=0 and limit=1 -> done 1 cycle after start, p_valid never asserted, count=0.
  - limit=2 -> single prime 2, count=1.
- Full range (WIDTH=8):
  - Stimulus: limit=255.
  - Required: 54 primes, last 251, no value >255 or repeat (cand never wraps); count=54. Compare each against a reference prime list.
- Ignored start:
  - Stimulus: during the run with limit=10, pulse start with limit=3.
  - Required: output identical to the basic run (2,3,5,7, count=4).
- Reset mid-run:
  - Stimulus: assert rst_n=0 while p_valid=1 with p_data=5.
  - Required: all outputs 0 immediately (asynchronously) and no done pulse. A new start with limit=7 afterwards yields 2,3,5,7.
